// File: rtl/ping_pong_monitor.sv
// Receive-side checker for a ping-pong counter: classifies every out/direction transition, counts bounces, latches the first violation.
// Latency: all outputs registered, one cycle after the sampling edge. No backpressure; samples qualified by mon_en.
// Optional build macro PPM_HOLD_CHECK_EN enables MODE (code 11) checking of enable/bounds against hold-vs-step behaviour.
module ping_pong_monitor #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mon_en,
    input  logic          cnt_en,
    input  logic [W-1:0]  max,
    input  logic [W-1:0]  min,
    input  logic          direction,
    input  logic [W-1:0]  out,
    input  logic          err_clr,
    output logic          bounce_top,
    output logic          bounce_bot,
    output logic          flip_det,
    output logic          hold_det,
    output logic [CW-1:0] bounce_cnt,
    output logic          error,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [W:0] ONE = (W+1)'(1);

    state_t        state;
    logic [W-1:0]  out_q, max_q, min_q;
    logic          dir_q, en_q;

    logic [W:0]    out_x, ref_x;
    logic          is_hold, is_up, is_dn, hold_exp;
    logic          hold_viol, step_viol;
    logic          ev_top, ev_bot, ev_flip, ev_hold;
    logic [1:0]    viol, viol_eff;
    logic          checking;

    // Widen before stepping so 15 -> 0 is a jump, not a wrap.
    assign out_x    = {1'b0, out};
    assign ref_x    = {1'b0, out_q};
    assign is_hold  = (out == out_q);
    assign is_up    = (out_x == ref_x + ONE);
    assign is_dn    = (out_x + ONE == ref_x);
    assign hold_exp = !en_q || (max_q <= min_q) || (out_q > max_q) || (out_q < min_q);

`ifdef PPM_HOLD_CHECK_EN
    assign hold_viol = !hold_exp;
    assign step_viol = hold_exp;
`else
    logic hold_exp_unused;
    assign hold_exp_unused = hold_exp;
    assign hold_viol = 1'b0;
    assign step_viol = 1'b0;
`endif

    always_comb begin
        viol    = 2'b00;
        ev_top  = 1'b0;
        ev_bot  = 1'b0;
        ev_flip = 1'b0;
        ev_hold = 1'b0;
        if (is_hold) begin
            ev_hold = 1'b1;
            if (hold_viol) viol = 2'b11;
        end else if (is_up || is_dn) begin
            if (step_viol) viol = 2'b11;
            if (is_up != direction) begin
                if (viol == 2'b00) viol = 2'b10;
            end else if (direction != dir_q) begin
                if (out_q == max_q && !direction)     ev_top  = 1'b1;
                else if (out_q == min_q && direction) ev_bot  = 1'b1;
                else                                  ev_flip = 1'b1;
            end
        end else begin
            viol = 2'b01;
        end
    end

    assign checking = mon_en && (state != IDLE);
    assign viol_eff = checking ? viol : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            dir_q      <= 1'b0;
            en_q       <= 1'b0;
            bounce_top <= 1'b0;
            bounce_bot <= 1'b0;
            flip_det   <= 1'b0;
            hold_det   <= 1'b0;
            bounce_cnt <= '0;
            error      <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            bounce_top <= checking && ev_top;
            bounce_bot <= checking && ev_bot;
            flip_det   <= checking && ev_flip;
            hold_det   <= checking && ev_hold;

            if (mon_en) begin
                out_q <= out;
                max_q <= max;
                min_q <= min;
                dir_q <= direction;
                en_q  <= cnt_en;
            end

            if (checking && (ev_top || ev_bot) && (bounce_cnt != {CW{1'b1}}))
                bounce_cnt <= bounce_cnt + CW'(1);

            // A fresh violation in the clearing cycle replaces the old code.
            if (viol_eff != 2'b00) begin
                error <= 1'b1;
                if (!error || err_clr) err_code <= viol_eff;
            end else if (err_clr) begin
                error    <= 1'b0;
                err_code <= 2'b00;
            end

            if (!mon_en)
                state <= IDLE;
            else if ((viol_eff != 2'b00) || (error && !err_clr))
                state <= FAULT;
            else
                state <= TRACK;
        end
    end

endmodule

// File: tb/tb_ping_pong_monitor.sv
// Randomized and directed bench for ping_pong_monitor against a transition-rule reference model.
module tb_ping_pong_monitor;

    localparam int W  = 4;
    localparam int CW = 8;
`ifdef PPM_HOLD_CHECK_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mon_en, cnt_en, direction, err_clr;
    logic [W-1:0]  max, min, out;
    logic          bounce_top, bounce_bot, flip_det, hold_det, error;
    logic [CW-1:0] bounce_cnt;
    logic [1:0]    err_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit have_ref;
    int r_out, r_max, r_min;
    bit r_dir, r_en;
    bit e_top, e_bot, e_flip, e_hold, e_err;
    int e_cnt, e_code;

    // Software ping-pong counter used as a stimulus source
    int c_out, c_max, c_min;
    bit c_dir, c_en;

    ping_pong_monitor #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .cnt_en(cnt_en),
        .max(max), .min(min), .direction(direction), .out(out), .err_clr(err_clr),
        .bounce_top(bounce_top), .bounce_bot(bounce_bot), .flip_det(flip_det),
        .hold_det(hold_det), .bounce_cnt(bounce_cnt), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        have_ref = 0; r_out = 0; r_max = 0; r_min = 0; r_dir = 0; r_en = 0;
        e_top = 0; e_bot = 0; e_flip = 0; e_hold = 0; e_err = 0; e_cnt = 0; e_code = 0;
    endtask

    task automatic model_step(input bit mon, input bit en, input int mx, input int mn,
                              input bit dir, input int o, input bit clr);
        int v = 0;
        int d;
        bit he;
        e_top = 0; e_bot = 0; e_flip = 0; e_hold = 0;
        if (mon && have_ref) begin
            d  = o - r_out;
            he = !r_en || (r_max <= r_min) || (r_out > r_max) || (r_out < r_min);
            if (d == 0) begin
                e_hold = 1;
                if (HC && !he) v = 3;
            end else if (d == 1 || d == -1) begin
                if (HC && he) v = 3;
                if ((d == 1) != dir) begin
                    if (v == 0) v = 2;
                end else if (dir != r_dir) begin
                    if (r_out == r_max && !dir)     e_top  = 1;
                    else if (r_out == r_min && dir) e_bot  = 1;
                    else                            e_flip = 1;
                end
            end else begin
                v = 1;
            end
        end
        if (mon) begin
            have_ref = 1; r_out = o; r_max = mx; r_min = mn; r_dir = dir; r_en = en;
        end else begin
            have_ref = 0;
        end
        if (v != 0) begin
            if (!e_err || clr) e_code = v;
            e_err = 1;
        end else if (clr) begin
            e_err = 0; e_code = 0;
        end
        if ((e_top || e_bot) && e_cnt < (1 << CW) - 1) e_cnt++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".top"},  int'(bounce_top), int'(e_top));
        check({tag, ".bot"},  int'(bounce_bot), int'(e_bot));
        check({tag, ".flip"}, int'(flip_det),   int'(e_flip));
        check({tag, ".hold"}, int'(hold_det),   int'(e_hold));
        check({tag, ".cnt"},  int'(bounce_cnt), e_cnt);
        check({tag, ".err"},  int'(error),      int'(e_err));
        check({tag, ".code"}, int'(err_code),   e_code);
    endtask

    // Called at a negedge: drive one sample, let it be clocked, then compare at the next negedge.
    task automatic step(input bit mon, input bit en, input int mx, input int mn,
                        input bit dir, input int o, input bit clr);
        mon_en = mon; cnt_en = en; max = W'(mx); min = W'(mn);
        direction = dir; out = W'(o); err_clr = clr;
        model_step(mon, en, mx, mn, dir, o, clr);
        @(negedge clk);
        check_all("model");
    endtask

    task automatic counter_advance();
        if (c_en && c_max > c_min && c_out <= c_max && c_out >= c_min) begin
            if (c_dir) begin
                if (c_out == c_max) begin c_dir = 0; c_out--; end
                else c_out++;
            end else begin
                if (c_out == c_min) begin c_dir = 1; c_out++; end
                else c_out--;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mon_en = 0; cnt_en = 0; max = '0; min = '0;
        direction = 0; out = '0; err_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Full 0..4..0 period
        c_max = 4; c_min = 0; c_en = 1; c_out = 0; c_dir = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, c_en, c_max, c_min, c_dir, c_out, 0);
            if (i == 5) check("top_pulse", int'(bounce_top), 1);
            if (i == 9) check("bot_pulse", int'(bounce_bot), 1);
            counter_advance();
        end
        check("period_cnt", int'(bounce_cnt), 2);
        check("period_err", int'(error), 0);

        // External flip away from bounds
        step(0, 1, 10, 3, 1, 4, 1);
        step(1, 1, 10, 3, 1, 4, 0);
        step(1, 1, 10, 3, 1, 5, 0);
        step(1, 1, 10, 3, 0, 4, 0);
        check("flip", int'(flip_det), 1);
        check("flip_no_top", int'(bounce_top), 0);

        // STEP, then DIR frozen behind it, then clear
        step(0, 1, 10, 3, 1, 6, 0);
        step(1, 1, 10, 3, 1, 6, 0);
        step(1, 1, 10, 3, 1, 8, 0);
        check("step_code", int'(err_code), 1);
        step(1, 1, 10, 3, 0, 9, 0);
        check("frozen_code", int'(err_code), 1);
        step(1, 1, 10, 3, 1, 10, 1);
        check("clr_err", int'(error), 0);
        check("clr_code", int'(err_code), 0);

        // Degenerate bounds: holds legal, a step is MODE only with hold checking
        step(0, 1, 9, 9, 1, 9, 1);
        step(1, 1, 9, 9, 1, 9, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 9, 9, 1, 9, 0);
            check("hold_det", int'(hold_det), 1);
            check("hold_noerr", int'(error), 0);
        end
        step(1, 1, 9, 9, 1, 10, 0);
        check("mode_code", int'(err_code), HC ? 3 : 0);

        // DIR violation, then asynchronous reset mid-cycle
        step(0, 1, 10, 0, 1, 2, 1);
        step(1, 1, 10, 0, 1, 2, 0);
        step(1, 1, 10, 0, 0, 3, 0);
        check("dir_code", int'(err_code), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_err",  int'(error), 0);
        check("arst_code", int'(err_code), 0);
        check("arst_cnt",  int'(bounce_cnt), 0);
        check("arst_ev",   int'({bounce_top, bounce_bot, flip_det, hold_det}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 10, 0, 1, 7, 0);
        check("post_rst_ev", int'({bounce_top, bounce_bot, flip_det, hold_det}), 0);

        // Saturation: a bounce every cycle
        c_max = 1; c_min = 0; c_en = 1; c_out = 0; c_dir = 1;
        for (int i = 0; i < 310; i++) begin
            step(1, c_en, c_max, c_min, c_dir, c_out, 0);
            counter_advance();
        end
        check("sat_cnt", int'(bounce_cnt), 255);

        // Randomized run with bound changes, enable toggles, flips and glitches
        c_max = 12; c_min = 2; c_out = 5; c_dir = 1; c_en = 1;
        for (int i = 0; i < 2000; i++) begin
            bit mon, clr;
            int o;
            mon = ($urandom_range(0, 99) >= 3);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) begin
                c_max = $urandom_range(0, 15);
                c_min = $urandom_range(0, 15);
            end
            if ($urandom_range(0, 24) == 0) c_en = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 15)) : c_out;
            step(mon, c_en, c_max, c_min, c_dir, o, clr);
            if ($urandom_range(0, 24) == 0) c_dir = !c_dir;
            counter_advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
